// File: rtl/md_ctrl.sv
// Multiply/divide controller holding architectural HI/LO for a pipelined core.
// Optional macro MD_DIV0_SKIP_EN: divide-by-zero completes after one busy cycle.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // state    | meaning
    // IDLE     | ready; MT ops execute here in one cycle
    // MULT_RUN | MULT/MULTU in flight, cnt counts down to write-back
    // DIV_RUN  | DIV/DIVU in flight, cnt counts down to write-back
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2
    } state_t;

    localparam int CNT_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic             sgn_q;

    logic [63:0] op_a64, op_b64, prod_d;
    logic        a_neg, b_neg, b_zero;
    logic [31:0] a_mag, b_mag, uq, ur, quot_d, rem_d;

    // Signed forms are handled by sign-extending to 64 bits before the multiply.
    always_comb begin
        op_a64 = {{32{sgn_q & a_q[31]}}, a_q};
        op_b64 = {{32{sgn_q & b_q[31]}}, b_q};
        prod_d = op_a64 * op_b64;
    end

    // Divide on magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend.
    always_comb begin
        a_neg  = sgn_q & a_q[31];
        b_neg  = sgn_q & b_q[31];
        b_zero = (b_q == 32'd0);
        a_mag  = a_neg ? (32'd0 - a_q) : a_q;
        b_mag  = b_neg ? (32'd0 - b_q) : b_q;
        uq     = 32'd0;
        ur     = 32'd0;
        if (!b_zero) begin
            uq = a_mag / b_mag;
            ur = a_mag % b_mag;
        end
        quot_d = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem_d  = a_neg ? (32'd0 - ur) : ur;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sgn_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (md_op)
                            3'd0, 3'd1: begin
                                a_q     <= srca;
                                b_q     <= srcb;
                                sgn_q   <= ~md_op[0];
                                cnt_q   <= MULT_LD;
                                busy_q  <= 1'b1;
                                state_q <= MULT_RUN;
                            end
                            3'd2, 3'd3: begin
                                a_q     <= srca;
                                b_q     <= srcb;
                                sgn_q   <= ~md_op[0];
`ifdef MD_DIV0_SKIP_EN
                                cnt_q   <= (srcb == 32'd0) ? CNT_ONE : DIV_LD;
`else
                                cnt_q   <= DIV_LD;
`endif
                                busy_q  <= 1'b1;
                                state_q <= DIV_RUN;
                            end
                            3'd4:    hi_q <= srca;
                            3'd5:    lo_q <= srca;
                            default: ;
                        endcase
                    end
                end
                MULT_RUN: begin
                    if (cnt_q == CNT_ONE) begin
                        hi_q    <= prod_d[63:32];
                        lo_q    <= prod_d[31:0];
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                DIV_RUN: begin
                    if (cnt_q == CNT_ONE) begin
                        if (!b_zero) begin
                            hi_q <= rem_d;
                            lo_q <= quot_d;
                        end
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign stall_md = md_use_d & (busy_q | (start & (md_op <= 3'd3)));

endmodule

// File: tb/tb_md_ctrl.sv
// Directed self-checking bench for md_ctrl: arithmetic, timing, stall, MT ops, reset.
`timescale 1ns/1ps
module tb_md_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, md_use_d;
    logic [2:0]  md_op;
    logic [31:0] srca, srcb;
    logic        busy, stall_md;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .srca(srca), .srcb(srcb), .md_use_d(md_use_d),
        .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue in the current cycle T, return the number of busy cycles seen.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int nb);
        start = 1'b1; md_op = op; srca = a; srcb = b;
        step();
        start = 1'b0; srca = $urandom; srcb = $urandom;
        nb = 0;
        while (busy === 1'b1 && nb < 50) begin
            nb++;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; md_op = 3'd4; srca = 32'hDEADBEEF; srcb = 0; md_use_d = 0;
        step(); step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall_md !== 1'b0) begin
            errors++;
            $display("FAIL reset_state busy=%b hi=%h lo=%h stall=%b required 0/0/0/0",
                     busy, hi, lo, stall_md);
        end
        reset = 1'b0;
        step();
        checks++;
        if (hi !== 32'd0) begin
            errors++;
            $display("FAIL reset_over_start hi=%h required 00000000", hi);
        end
    endtask

    task automatic test_mult();
        int nb;
        run_op(3'd0, 32'hFFFFFFFD, 32'd5, nb);
        checks++;
        if (nb !== 5 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
            errors++;
            $display("FAIL mult busy=%0d hi=%h lo=%h required 5 ffffffff fffffff1", nb, hi, lo);
        end
        run_op(3'd1, 32'hFFFFFFFD, 32'd5, nb);
        checks++;
        if (nb !== 5 || hi !== 32'h00000004 || lo !== 32'hFFFFFFF1) begin
            errors++;
            $display("FAIL multu busy=%0d hi=%h lo=%h required 5 00000004 fffffff1", nb, hi, lo);
        end
        run_op(3'd0, 32'h80000000, 32'h80000000, nb);
        checks++;
        if (hi !== 32'h40000000 || lo !== 32'h00000000) begin
            errors++;
            $display("FAIL mult_minint hi=%h lo=%h required 40000000 00000000", hi, lo);
        end
    endtask

    task automatic test_div();
        int nb;
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, nb);
        checks++;
        if (nb !== 10 || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL div busy=%0d hi=%h lo=%h required 10 ffffffff fffffffd", nb, hi, lo);
        end
        run_op(3'd3, 32'd7, 32'd2, nb);
        checks++;
        if (nb !== 10 || lo !== 32'd3 || hi !== 32'd1) begin
            errors++;
            $display("FAIL divu busy=%0d hi=%h lo=%h required 10 00000001 00000003", nb, hi, lo);
        end
        run_op(3'd2, 32'd7, 32'hFFFFFFFE, nb);
        checks++;
        if (lo !== 32'hFFFFFFFD || hi !== 32'd1) begin
            errors++;
            $display("FAIL div_negdivisor hi=%h lo=%h required 00000001 fffffffd", hi, lo);
        end
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, nb);
        checks++;
        if (lo !== 32'h7FFFFFFC || hi !== 32'd1) begin
            errors++;
            $display("FAIL divu_big hi=%h lo=%h required 00000001 7ffffffc", hi, lo);
        end
    endtask

    task automatic test_stall_ignore();
        int n;
        md_use_d = 1'b1;
        start = 1'b1; md_op = 3'd0; srca = 32'd6; srcb = 32'd7;
        #1;
        checks++;
        if (stall_md !== 1'b1) begin
            errors++;
            $display("FAIL stall_issue stall_md=%b required 1", stall_md);
        end
        step();
        start = 1'b0;
        n = 0;
        for (int i = 1; i <= 5; i++) begin
            if (i == 2) begin
                start = 1'b1; md_op = 3'd2; srca = 32'd100; srcb = 32'd3;
            end else begin
                start = 1'b0; srca = 32'hFFFF0000; srcb = 32'h0000FFFF;
            end
            #1;
            if (stall_md === 1'b1 && busy === 1'b1) n++;
            step();
        end
        start = 1'b0;
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL stall_busy cycles=%0d required 5", n);
        end
        checks++;
        if (stall_md !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd42) begin
            errors++;
            $display("FAIL stall_end stall=%b busy=%b hi=%h lo=%h required 0 0 00000000 0000002a",
                     stall_md, busy, hi, lo);
        end
        step();
        checks++;
        if (busy !== 1'b0 || lo !== 32'd42) begin
            errors++;
            $display("FAIL ignored_start busy=%b lo=%h required 0 0000002a", busy, lo);
        end
        md_use_d = 1'b0;
    endtask

    task automatic test_mt_ops();
        int nb;
        logic [31:0] lo_before;
        lo_before = lo;
        run_op(3'd4, 32'h12345678, 32'd0, nb);
        checks++;
        if (nb !== 0 || hi !== 32'h12345678 || lo !== lo_before) begin
            errors++;
            $display("FAIL mthi busy=%0d hi=%h lo=%h required 0 12345678 %h", nb, hi, lo, lo_before);
        end
        run_op(3'd5, 32'h87654321, 32'd0, nb);
        checks++;
        if (nb !== 0 || lo !== 32'h87654321 || hi !== 32'h12345678) begin
            errors++;
            $display("FAIL mtlo busy=%0d hi=%h lo=%h required 0 12345678 87654321", nb, hi, lo);
        end
        md_use_d = 1'b1;
        start = 1'b1; md_op = 3'd6; srca = 32'hCAFEF00D;
        #1;
        checks++;
        if (stall_md !== 1'b0) begin
            errors++;
            $display("FAIL reserved_stall stall_md=%b required 0", stall_md);
        end
        step();
        start = 1'b0; md_use_d = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h12345678 || lo !== 32'h87654321) begin
            errors++;
            $display("FAIL reserved_noop busy=%b hi=%h lo=%h required 0 12345678 87654321",
                     busy, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int nb;
        run_op(3'd0, 32'd3, 32'd4, nb);
        run_op(3'd3, 32'd20, 32'd6, nb);
        checks++;
        if (nb !== 10 || lo !== 32'd3 || hi !== 32'd2) begin
            errors++;
            $display("FAIL back_to_back busy=%0d hi=%h lo=%h required 10 00000002 00000003", nb, hi, lo);
        end
    endtask

    task automatic test_reset_mid_op();
        int bad;
        start = 1'b1; md_op = 3'd2; srca = 32'd100; srcb = 32'd7;
        step();
        start = 1'b0;
        step(); step(); step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_t4 busy=%b required 1", busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL late_writeback bad_cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_div0();
        int nb, exp_nb;
`ifdef MD_DIV0_SKIP_EN
        exp_nb = 1;
`else
        exp_nb = 10;
`endif
        run_op(3'd4, 32'hA, 32'd0, nb);
        run_op(3'd5, 32'hB, 32'd0, nb);
        run_op(3'd2, 32'd5, 32'd0, nb);
        checks++;
        if (nb !== exp_nb || hi !== 32'hA || lo !== 32'hB) begin
            errors++;
            $display("FAIL div0 busy=%0d hi=%h lo=%h required %0d 0000000a 0000000b",
                     nb, hi, lo, exp_nb);
        end
        run_op(3'd3, 32'd9, 32'd0, nb);
        checks++;
        if (nb !== exp_nb || hi !== 32'hA || lo !== 32'hB) begin
            errors++;
            $display("FAIL divu0 busy=%0d hi=%h lo=%h required %0d 0000000a 0000000b",
                     nb, hi, lo, exp_nb);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_stall_ignore();
        test_mt_ops();
        test_back_to_back();
        test_reset_mid_op();
        test_div0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning the number of busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning the number of busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the block uses only this clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request from the EX stage to issue md_op.
REQ-006 SHALL have port md_op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved.
REQ-007 SHALL have port srca  input  32  forwarded EX operand A, i.e. rs, dividend or MT source.
REQ-008 SHALL have port srcb  input  32  forwarded EX operand B, i.e. rt or divisor.
REQ-009 SHALL have port md_use_d  input  1  the D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 SHALL have port busy  output  1  an operation is in progress.
REQ-011 SHALL have port stall_md  output  1  request to freeze the F/D stages and bubble EX.
REQ-012 SHALL have port hi  output  32  architectural HI register.
REQ-013 SHALL have port lo  output  32  architectural LO register.

Function
REQ-014 SHALL implement the states IDLE, MULT_RUN and DIV_RUN, plus a down-counter cnt whose width fits DIV_CYCLES.
REQ-015 SHALL, in IDLE with start=1 and md_op=0/1, latch srca/srcb, load cnt=MULT_CYCLES and move to MULT_RUN.
REQ-016 SHALL, in IDLE with start=1 and md_op=2/3, latch srca/srcb, load cnt=DIV_CYCLES and move to DIV_RUN.
REQ-017 SHALL hold busy=1 in the RUN states: start at cycle T gives busy=1 for cycles T+1..T+N and busy=0 at T+N+1.
REQ-018 SHALL update hi/lo at the clock edge ending cycle T+N, so new values are visible in the same cycle busy falls, then return to IDLE.
REQ-019 SHALL compute MULT as a signed 32x32 product and MULTU as unsigned, with hi = product[63:32] and lo = product[31:0].
REQ-020 SHALL compute DIV as signed with the quotient truncated toward zero, lo = quotient and hi = remainder carrying the sign of the dividend; DIVU SHALL compute the unsigned equivalent.
REQ-021 SHALL leave hi/lo unchanged when the divisor is 0, and still complete in DIV_CYCLES unless MD_DIV0_SKIP_EN is defined.
REQ-022 SHALL execute MTHI (hi<=srca) or MTLO (lo<=srca) in one cycle when issued in IDLE with start=1, with no busy cycles.
REQ-023 SHALL treat reserved md_op values as a no-op that causes no state change.
REQ-024 SHALL ignore start while busy=1; operands, cnt and the operation in flight stay unaffected.
REQ-025 SHALL drive stall_md = md_use_d & (busy | (start & md_op<=3)) as purely combinational logic.
REQ-026 SHALL use only the latched operands during the RUN states; srca/srcb changes after issue have no effect.

Reset
REQ-027 SHALL, when reset=1 at a rising edge, set state=IDLE, cnt=0, busy=0, hi=0, lo=0 and clear the latched operands.
REQ-028 SHALL, on reset mid-operation, abandon the operation so that hi/lo read 0 and no late write-back occurs.
REQ-029 SHALL give reset priority over a start in the same cycle.

Configuration
REQ-030 SHALL support macro MD_DIV0_SKIP_EN, which selects the divide-by-zero timing.
REQ-031 SHALL, when MD_DIV0_SKIP_EN is defined, finish DIV/DIVU with srcb=0 after one busy cycle (busy at T+1 only, IDLE at T+2) with hi/lo unchanged.
REQ-032 SHALL, when MD_DIV0_SKIP_EN is undefined, run divide-by-zero for the full DIV_CYCLES with hi/lo unchanged.

Verification
REQ-033 SHALL verify MULT: srca=0xFFFFFFFD and srcb=5 -> busy for 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFF1; the same operands under MULTU -> hi=0x00000004 and lo=0xFFFFFFF1.
REQ-034 SHALL verify DIV: srca=0xFFFFFFF9 and srcb=2 -> busy for 10 cycles, then lo=0xFFFFFFFD and hi=0xFFFFFFFF; DIVU with 7/2 -> lo=3 and hi=1.
REQ-035 SHALL verify stall and ignored start: MULT issued with md_use_d=1 held -> stall_md=1 in cycles T..T+5 and 0 at T+6; a start during busy is ignored and the result is unchanged.
REQ-036 SHALL verify MT ops: MTHI srca=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy stays 0, lo unchanged.
REQ-037 SHALL verify reset mid-operation: DIV started, reset asserted at T+4 -> busy=0 and hi=lo=0 from T+5, with no write at T+10.
REQ-038 SHALL verify divide-by-zero: DIV with srcb=0 and hi/lo preloaded to 0xA/0xB -> hi/lo unchanged; busy lasts 1 cycle with MD_DIV0_SKIP_EN defined and 10 cycles without it.
